// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver.
// A 2-flop synchronizer feeds a framing FSM that finds the start bit, takes a
// 3-sample majority vote mid-bit, shifts data LSB-first, optionally checks
// parity, checks the stop bit and emits one-cycle result pulses.
module uart_rx_core #(
    parameter int Data_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rx_in,
    input  logic [5:0]            i_prescale,
    input  logic                  i_parity_enable,
    input  logic                  i_parity_type,
    output logic [Data_WIDTH-1:0] o_data,
    output logic                  o_data_valid,
    output logic                  o_parity_error,
    output logic                  o_stop_error
);

    localparam int BitCntW = (Data_WIDTH > 1) ? $clog2(Data_WIDTH) : 1;
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(Data_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    // Only 8, 16 and 32 are supported ratios; anything else falls back to 8.
    function automatic logic [5:0] legal_prescale(input logic [5:0] p);
        case (p)
            6'd8, 6'd16, 6'd32: return p;
            default:            return 6'd8;
        endcase
    endfunction

    // Synchronizer
    logic rx_meta_q;
    logic rx_s_q;

    // Frame state
    state_e                  state_q;
    logic [5:0]              edge_cnt_q;
    logic [BitCntW-1:0]      bit_cnt_q;
    logic [5:0]              prescale_q;
    logic                    parity_en_q;
    logic                    parity_type_q;
    logic [1:0]              samp_q;
    logic [Data_WIDTH-1:0]   shift_q;
    logic                    par_err_q;

    // Registered outputs
    logic [Data_WIDTH-1:0]   data_q;
    logic                    data_valid_q;
    logic                    parity_error_q;
    logic                    stop_error_q;

    // Decode helpers
    logic [5:0] half;
    logic       last_edge;
    logic       samp_lo;
    logic       samp_mid;
    logic       decide;
    logic       maj;
    logic       par_exp;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let both flops sample the old values on the same edge,
            // which is what makes this a two-stage shift rather than a single wire.
            rx_meta_q <= i_rx_in;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Sample-point decode and majority vote over the two captured samples plus the live one.
    always_comb begin
        // NOTE: every signal gets a value on every path here, so no latch can be inferred.
        half      = prescale_q >> 1;
        last_edge = (edge_cnt_q == prescale_q - 6'd1);
        samp_lo   = (edge_cnt_q == half - 6'd1);
        samp_mid  = (edge_cnt_q == half);
        decide    = (edge_cnt_q == half + 6'd1);
        maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
        par_exp   = parity_type_q ? ~^shift_q : ^shift_q;
    end

    // Framing FSM with registered data and pulse outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= ST_IDLE;
            edge_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            prescale_q     <= 6'd8;
            parity_en_q    <= 1'b0;
            parity_type_q  <= 1'b0;
            samp_q         <= 2'b11;
            shift_q        <= '0;
            par_err_q      <= 1'b0;
            data_q         <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
        end else begin
            // Pulses are low unless explicitly raised this cycle.
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;

            if (state_q != ST_IDLE) begin
                if (samp_lo)  samp_q[0] <= rx_s_q;
                if (samp_mid) samp_q[1] <= rx_s_q;
                edge_cnt_q <= last_edge ? 6'd0 : edge_cnt_q + 6'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (!rx_s_q) begin
                        state_q       <= ST_START;
                        edge_cnt_q    <= 6'd0;
                        bit_cnt_q     <= '0;
                        par_err_q     <= 1'b0;
                        prescale_q    <= legal_prescale(i_prescale);
                        parity_en_q   <= i_parity_enable;
                        parity_type_q <= i_parity_type;
                    end
                end

                ST_START: begin
                    if (decide && maj) begin
                        // Start bit did not hold low through mid-bit: treat as a glitch.
                        state_q    <= ST_IDLE;
                        edge_cnt_q <= 6'd0;
                    end else if (last_edge) begin
                        state_q   <= ST_DATA;
                        bit_cnt_q <= '0;
                    end
                end

                ST_DATA: begin
                    if (decide) shift_q <= {maj, shift_q[Data_WIDTH-1:1]};
                    if (last_edge) begin
                        if (bit_cnt_q == LastBit) begin
                            state_q <= parity_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (decide)    par_err_q <= (maj != par_exp);
                    if (last_edge) state_q   <= ST_STOP;
                end

                ST_STOP: begin
                    if (decide) begin
                        stop_error_q   <= ~maj;
                        parity_error_q <= par_err_q;
                        if (maj && !par_err_q) begin
                            data_q       <= shift_q;
                            data_valid_q <= 1'b1;
                        end
                    end
                    if (last_edge) state_q <= ST_IDLE;
                end

                default: begin
                    state_q    <= ST_IDLE;
                    edge_cnt_q <= 6'd0;
                end
            endcase
        end
    end

    assign o_data         = data_q;
    assign o_data_valid   = data_valid_q;
    assign o_parity_error = parity_error_q;
    assign o_stop_error   = stop_error_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed testbench for uart_rx_core: drives whole frames on the serial line
// and checks result pulses and received data against hand-computed values.
module tb_uart_rx_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_in;
    logic [5:0] prescale;
    logic       parity_enable;
    logic       parity_type;
    logic [7:0] data;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;

    int total = 0;
    int bad   = 0;

    // Pulse monitor state
    int         n_valid = 0;
    int         n_perr  = 0;
    int         n_serr  = 0;
    int         n_wide  = 0;
    logic [2:0] prev_p  = 3'b000;
    logic [7:0] vlog[$];

    // Snapshot of counters at the start of a step
    int b_valid;
    int b_perr;
    int b_serr;

    always #5 clk = ~clk;

    uart_rx_core #(.Data_WIDTH(8)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_rx_in         (rx_in),
        .i_prescale      (prescale),
        .i_parity_enable (parity_enable),
        .i_parity_type   (parity_type),
        .o_data          (data),
        .o_data_valid    (data_valid),
        .o_parity_error  (parity_error),
        .o_stop_error    (stop_error)
    );

    // Count pulses, log received words, and flag any pulse lasting more than one cycle.
    always @(negedge clk) begin
        if (data_valid) begin
            n_valid <= n_valid + 1;
            vlog.push_back(data);
        end
        if (parity_error) n_perr <= n_perr + 1;
        if (stop_error)   n_serr <= n_serr + 1;
        if ((prev_p & {data_valid, parity_error, stop_error}) != 3'b000) n_wide <= n_wide + 1;
        prev_p <= {data_valid, parity_error, stop_error};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        #1;
        b_valid = n_valid;
        b_perr  = n_perr;
        b_serr  = n_serr;
    endtask

    task automatic check_deltas(input string tag, input int dv, input int dp, input int ds);
        #1;
        check({tag, "_valid"}, 32'(n_valid - b_valid), 32'(dv));
        check({tag, "_perr"},  32'(n_perr - b_perr),   32'(dp));
        check({tag, "_serr"},  32'(n_serr - b_serr),   32'(ds));
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b, input int p);
        rx_in = b;
        repeat (p) @(negedge clk);
    endtask

    task automatic cfg(input int p, input logic pen, input logic ptype);
        prescale      = 6'(p);
        parity_enable = pen;
        parity_type   = ptype;
    endtask

    // One frame on the line; with scramble the config inputs are disturbed after the start bit.
    task automatic send_frame(input logic [7:0] d, input int p, input logic pen, input logic pbit,
                              input logic stop, input bit scramble);
        logic [5:0] sv_p;
        logic       sv_en;
        logic       sv_ty;
        sv_p  = prescale;
        sv_en = parity_enable;
        sv_ty = parity_type;
        drive_bit(1'b0, p);
        if (scramble) begin
            prescale      = 6'd16;
            parity_enable = ~sv_en;
            parity_type   = ~sv_ty;
        end
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pen) drive_bit(pbit, p);
        drive_bit(stop, p);
        if (scramble) begin
            prescale      = sv_p;
            parity_enable = sv_en;
            parity_type   = sv_ty;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rx_in = 1'b1;
        cfg(8, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("rst_data",  32'(data),         32'h0);
        check("rst_valid", 32'(data_valid),   32'h0);
        check("rst_perr",  32'(parity_error), 32'h0);
        check("rst_serr",  32'(stop_error),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);

        // 1: P=8, even parity, 0xA5 with parity bit 0; config disturbed mid-frame.
        cfg(8, 1'b1, 1'b0);
        snap();
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(16);
        check_deltas("t1", 1, 0, 0);
        check("t1_data", 32'(data), 32'hA5);

        // 2: P=16, odd parity; good parity 1, then bad parity 0.
        cfg(16, 1'b1, 1'b1);
        snap();
        send_frame(8'hA5, 16, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(32);
        check_deltas("t2a", 1, 0, 0);
        check("t2a_data", 32'(data), 32'hA5);
        snap();
        send_frame(8'hA5, 16, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(32);
        check_deltas("t2b", 0, 1, 0);
        check("t2b_data", 32'(data), 32'hA5);

        // 3: P=8, no parity; 0x3C with stop bit low, then a good 0x55.
        cfg(8, 1'b0, 1'b0);
        snap();
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(16);
        check_deltas("t3a", 0, 0, 1);
        check("t3a_data", 32'(data), 32'hA5);
        snap();
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(16);
        check_deltas("t3b", 1, 0, 0);
        check("t3b_data", 32'(data), 32'h55);

        // 4: P=16; 3-clock glitch is rejected, then 0x81 is received.
        cfg(16, 1'b0, 1'b0);
        snap();
        drive_bit(1'b0, 3);
        idle(40);
        check_deltas("t4_glitch", 0, 0, 0);
        check("t4_glitch_data", 32'(data), 32'h55);
        snap();
        send_frame(8'h81, 16, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(32);
        check_deltas("t4", 1, 0, 0);
        check("t4_data", 32'(data), 32'h81);

        // 5: P=32, no parity; 0x00 then 0xFF back to back.
        cfg(32, 1'b0, 1'b0);
        snap();
        send_frame(8'h00, 32, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(64);
        check_deltas("t5", 2, 0, 0);
        check("t5_first",  32'((vlog.size() >= b_valid + 2) ? vlog[b_valid]     : 8'hxx), 32'h00);
        check("t5_second", 32'((vlog.size() >= b_valid + 2) ? vlog[b_valid + 1] : 8'hxx), 32'hFF);

        // 6: P=8; reset during data bit 4, then 0x5A.
        cfg(8, 1'b0, 1'b0);
        snap();
        drive_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 8);
        drive_bit(1'b0, 4);
        rst_n = 1'b0;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("t6_rst_data",  32'(data),         32'h0);
        check("t6_rst_valid", 32'(data_valid),   32'h0);
        check("t6_rst_perr",  32'(parity_error), 32'h0);
        check("t6_rst_serr",  32'(stop_error),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(100);
        check_deltas("t6_abort", 0, 0, 0);
        snap();
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(16);
        check_deltas("t6", 1, 0, 0);
        check("t6_data", 32'(data), 32'h5A);

        #1;
        check("pulse_width", 32'(n_wide), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
